ifetch_prefetch_queue: RTL

Parametrised instruction-fetch front end that replaces the single-entry IF buffer with an N-deep prefetch queue and up to MAX_OUTSTANDING in-flight instruction SRAM requests. It sits between the instruction SRAM-like interface (req/addr_ok/data_ok) and the ID stage. It generates sequential PCs and applies exception/ertn/branch redirects with fixed priority. Responses to cancelled requests are dropped through a discard counter, so no bubble-prone handshake registers are needed.

---
 rtl/ifetch_prefetch_queue_if.sv | 43 ++++
 rtl/ifetch_prefetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue_if
//
// Purpose:
//   Bundles the SRAM-like instruction fetch bus that connects the fetch
//   front end to the instruction memory. Each request is a req/addr_ok
//   handshake. Each response is a single-cycle data_ok pulse carrying rdata.
//   Responses come back in request order.
//
// Signals:
//   req      fetch request (front end -> memory)
//   addr     32-bit fetch address (front end -> memory)
//   addr_ok  request accepted this cycle (memory -> front end)
//   data_ok  in-order response valid (memory -> front end)
//   rdata    32-bit response data (memory -> front end)
//
// Modports:
//   master   the fetch front end
//   slave    the instruction memory
// ---------------------------------------------------------------------------
interface ifetch_prefetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output addr_ok,
        output data_ok,
        output rdata
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue
//
// Purpose:
//   Instruction-fetch front end with an N-deep prefetch queue. It keeps up
//   to MAX_OUTSTANDING instruction SRAM requests in flight.
//   - It generates sequential fetch PCs.
//   - It applies exception, ertn and branch redirects with fixed priority:
//     exception first, then ertn, then branch.
//   - Responses to requests made before a redirect are dropped through a
//     discard counter.
//   - A misaligned fetch PC does not go to memory. Instead it produces a
//     single address-error entry and then halts fetching until the next
//     redirect.
//
// Parameters:
//   FIFO_DEPTH       prefetch queue entries (power of two, >= 2)
//   MAX_OUTSTANDING  accepted-but-unanswered requests (1..FIFO_DEPTH)
//   RESET_PC         first fetch address after reset
//
// Ports:
//   clk, resetn              clock and asynchronous active-low reset
//   inst_sram                SRAM-like fetch bus (master side)
//   wb_ex, ex_entry          exception redirect and its target
//   ertn_flush, ertn_entry   ertn redirect and its target
//   br_taken, br_target      branch redirect and its target
//   br_stall                 blocks new requests; responses still complete
//   ds_allowin               ID accepts the head entry
//   fs2ds_valid              head entry valid
//   fs2ds_pc                 head PC
//   fs2ds_inst               head instruction (0 for an address-error entry)
//   fs2ds_adef               head is a misaligned-PC fetch exception
// ---------------------------------------------------------------------------
module ifetch_prefetch_queue #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
    input  logic                    clk,
    input  logic                    resetn,
    ifetch_prefetch_queue_if.master inst_sram,
    input  logic                    wb_ex,
    input  logic [31:0]             ex_entry,
    input  logic                    ertn_flush,
    input  logic [31:0]             ertn_entry,
    input  logic                    br_taken,
    input  logic [31:0]             br_target,
    input  logic                    br_stall,
    input  logic                    ds_allowin,
    output logic                    fs2ds_valid,
    output logic [31:0]             fs2ds_pc,
    output logic [31:0]             fs2ds_inst,
    output logic                    fs2ds_adef
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int PPW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] MAX_OUT_C = CNTW'(MAX_OUTSTANDING);
    localparam logic [CNTW:0]   DEPTH_C   = (CNTW + 1)'(FIFO_DEPTH);
    localparam logic [PTRW-1:0] PTR_ONE   = PTRW'(1);
    localparam logic [PPW-1:0]  PEND_ONE  = PPW'(1);
    localparam logic [PPW-1:0]  PEND_LAST = PPW'(MAX_OUTSTANDING - 1);

    // Fetch state
    logic [31:0]     r_fetchPc;
    logic            r_halt;
    logic [CNTW-1:0] r_outCnt;
    logic [CNTW-1:0] r_discardCnt;

    // PCs of accepted requests, in issue order, waiting for their responses
    logic [31:0]     r_pendPc [MAX_OUTSTANDING];
    logic [PPW-1:0]  r_pendWr;
    logic [PPW-1:0]  r_pendRd;

    // Prefetch queue storage and bookkeeping
    logic            r_fifoAdef [FIFO_DEPTH];
    logic [31:0]     r_fifoPc   [FIFO_DEPTH];
    logic [31:0]     r_fifoInst [FIFO_DEPTH];
    logic [PTRW-1:0] r_wrPtr;
    logic [PTRW-1:0] r_rdPtr;
    logic [CNTW-1:0] r_fifoCnt;

    logic            w_redirect;
    logic [31:0]     w_target;
    logic            w_aligned;
    logic [CNTW-1:0] w_liveInFlight;
    logic [CNTW:0]   w_creditUse;
    logic            w_canIssue;
    logic            w_req;
    logic            w_accept;
    logic            w_resp;
    logic            w_respPush;
    logic            w_adefPush;
    logic            w_push;
    logic [31:0]     w_pushPc;
    logic [31:0]     w_pushInst;
    logic            w_fifoNotEmpty;
    logic            w_valid;
    logic            w_pop;

    // Redirect detection and the target of the highest-priority source.
    assign w_redirect = wb_ex | ertn_flush | br_taken;
    assign w_target   = wb_ex      ? ex_entry   :
                        ertn_flush ? ertn_entry : br_target;
    assign w_aligned  = (r_fetchPc[1:0] == 2'b00);

    // A new entry may be produced only when the queue still has room for it.
    // The room must also cover every live response that is still on its way.
    // Responses that will be discarded do not use up any room.
    // Because of this check, the queue can never overflow.
    assign w_liveInFlight = r_outCnt - r_discardCnt;
    assign w_creditUse    = {1'b0, w_liveInFlight} + {1'b0, r_fifoCnt};
    assign w_canIssue     = (r_outCnt < MAX_OUT_C) && (w_creditUse < DEPTH_C);

    // Request qualification.
    // resetn is included so that req reads 0 during reset.
    assign w_req    = resetn & w_canIssue & ~br_stall & ~r_halt & ~w_redirect & w_aligned;
    assign w_accept = w_req & inst_sram.addr_ok;

    // A data_ok with nothing outstanding is stale. It is ignored so the
    // counters cannot underflow.
    assign w_resp     = inst_sram.data_ok & (r_outCnt != '0);
    assign w_respPush = w_resp & ~w_redirect & (r_discardCnt == '0);

    // A misaligned PC normally cannot coincide with a live response: the
    // redirect that produced the PC marked every older response for discard.
    // The response is still given precedence as a safeguard.
    assign w_adefPush = w_canIssue & ~w_redirect & ~r_halt & ~w_aligned & ~w_respPush;

    assign w_push     = w_respPush | w_adefPush;
    assign w_pushPc   = w_adefPush ? r_fetchPc : r_pendPc[r_pendRd];
    assign w_pushInst = w_adefPush ? 32'h0 : inst_sram.rdata;

    // During a redirect the head is hidden from ID, so no pop can happen.
    assign w_fifoNotEmpty = (r_fifoCnt != '0);
    assign w_valid        = w_fifoNotEmpty & ~w_redirect;
    assign w_pop          = w_valid & ds_allowin;

    assign inst_sram.req  = w_req;
    assign inst_sram.addr = r_fetchPc;

    assign fs2ds_valid = w_valid;
    assign fs2ds_pc    = w_fifoNotEmpty ? r_fifoPc[r_rdPtr]   : 32'h0;
    assign fs2ds_inst  = w_fifoNotEmpty ? r_fifoInst[r_rdPtr] : 32'h0;
    assign fs2ds_adef  = w_fifoNotEmpty ? r_fifoAdef[r_rdPtr] : 1'b0;

    // Fetch PC and halt flag.
    // - A redirect overrides everything else.
    // - An accepted request advances the PC.
    // - An address-error entry parks fetching until the next redirect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetchPc <= RESET_PC;
            r_halt    <= 1'b0;
        end else if (w_redirect) begin
            r_fetchPc <= w_target;
            r_halt    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end
            if (w_adefPush) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Outstanding and discard counters.
    // On a redirect, every request still unanswered after this cycle becomes
    // stale. A response arriving in the redirect cycle is one of them and
    // is dropped immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outCnt     <= '0;
            r_discardCnt <= '0;
        end else begin
            case ({w_accept, w_resp})
                2'b10:   r_outCnt <= r_outCnt + CNT_ONE;
                2'b01:   r_outCnt <= r_outCnt - CNT_ONE;
                default: r_outCnt <= r_outCnt;
            endcase

            if (w_redirect) begin
                r_discardCnt <= w_resp ? (r_outCnt - CNT_ONE) : r_outCnt;
            end else if (w_resp && (r_discardCnt != '0)) begin
                r_discardCnt <= r_discardCnt - CNT_ONE;
            end
        end
    end

    // Pending-PC queue pointers.
    // The pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
    // Entries are popped for every response, discarded or not, so the
    // queue stays aligned with the memory's in-order responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pendWr <= '0;
            r_pendRd <= '0;
        end else begin
            if (w_accept) begin
                r_pendWr <= (r_pendWr == PEND_LAST) ? '0 : r_pendWr + PEND_ONE;
            end
            if (w_resp) begin
                r_pendRd <= (r_pendRd == PEND_LAST) ? '0 : r_pendRd + PEND_ONE;
            end
        end
    end

    // Pending-PC storage.
    // It needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pendPc[r_pendWr] <= r_fetchPc;
        end
    end

    // Prefetch queue pointers and occupancy.
    // A redirect empties the queue in one cycle. Pushes are already
    // suppressed in that cycle, and the masked valid blocks pops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else if (w_redirect) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + CNT_ONE;
                2'b01:   r_fifoCnt <= r_fifoCnt - CNT_ONE;
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    // Prefetch queue storage.
    // The head is only exposed when the queue is non-empty, so this storage
    // needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAdef[r_wrPtr] <= w_adefPush;
            r_fifoPc[r_wrPtr]   <= w_pushPc;
            r_fifoInst[r_wrPtr] <= w_pushInst;
        end
    end

endmodule
